// File: rtl/cnn_accel_pkg.sv
// rtl/cnn_accel_pkg.sv - shared scheduler state encoding and block defaults
package cnn_accel_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sched_state_t;

    localparam int DEF_LANES      = 16;
    localparam int DEF_FIFO_DEPTH = 4;

    // Tag layout: bit 0 = last group of a pixel, bit 1 = last beat of the job
    localparam int TAG_W = 2;

endpackage

// File: rtl/sync_fifo_tagged.sv
// rtl/sync_fifo_tagged.sv - output buffer holding rectified beats plus their tags
module sync_fifo_tagged
    import cnn_accel_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic [WIDTH-1:0]               push_data,
    input  logic [TAG_W-1:0]               push_tags,
    input  logic                           pop,
    output logic [WIDTH-1:0]               pop_data,
    output logic [TAG_W-1:0]               pop_tags,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] data_mem [DEPTH];
    logic [TAG_W-1:0] tag_mem  [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the head slot, so push-while-full is fine then
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (!do_push && do_pop) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            data_mem[wr_ptr] <= push_data;
            tag_mem[wr_ptr]  <= push_tags;
        end
    end

    assign pop_data = empty ? '0 : data_mem[rd_ptr];
    assign pop_tags = empty ? '0 : tag_mem[rd_ptr];

    no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));

endmodule

// File: rtl/conv2d_relu_sched.sv
// rtl/conv2d_relu_sched.sv - credit-based scheduler feeding an external ReLU array into a tagged output buffer
module conv2d_relu_sched
    import cnn_accel_pkg::*;
#(
    parameter int DATA_WIDTH = 14,
    parameter int LANES      = DEF_LANES,
    parameter int RELU_LAT   = 1,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [7:0]                  cfg_groups,
    input  logic [15:0]                 cfg_pixels,
    output logic                        busy,
    output logic                        done,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_WIDTH*LANES-1:0] in_data,
    output logic                        relu_en,
    output logic [DATA_WIDTH*LANES-1:0] relu_data,
    input  logic [DATA_WIDTH*LANES-1:0] relu_out,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_WIDTH*LANES-1:0] out_data,
    output logic                        out_last_group,
    output logic                        out_last
);

    localparam int W  = DATA_WIDTH * LANES;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    sched_state_t   state;
    sched_state_t   state_next;
    logic [7:0]     groups_q;
    logic [15:0]    pixels_q;
    logic [7:0]     group_cnt;
    logic [15:0]    pixel_cnt;
    logic [W-1:0]   relu_hold;
    logic [RELU_LAT-1:0] dl_vld;
    logic [TAG_W-1:0]    dl_tag [RELU_LAT];
    logic [CW-1:0]  inflight;
    logic [CW-1:0]  fifo_count;
    logic [CW:0]    credit_used;
    logic           fifo_empty;
    logic [TAG_W-1:0] head_tags;
    logic           fire;
    logic           last_group;
    logic           last_beat;

    // Beats in the ReLU pipe still own a buffer slot, so they count against credit
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RELU_LAT; i++) begin
            inflight = inflight + CW'(dl_vld[i]);
        end
    end

    assign credit_used = {1'b0, fifo_count} + {1'b0, inflight};
    assign in_ready    = (state == ST_RUN) && (credit_used < (CW+1)'(FIFO_DEPTH));
    assign fire        = in_valid && in_ready;
    assign last_group  = (group_cnt == groups_q - 8'd1);
    assign last_beat   = last_group && (pixel_cnt == pixels_q - 16'd1);
    assign relu_en     = fire;
    assign relu_data   = fire ? in_data : relu_hold;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = (state != ST_IDLE);
        done       = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    if (cfg_groups == 8'd0 || cfg_pixels == 16'd0) state_next = ST_DONE;
                    else                                           state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (fire && last_beat) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (inflight == '0 && fifo_empty) state_next = ST_DONE;
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            groups_q  <= '0;
            pixels_q  <= '0;
            group_cnt <= '0;
            pixel_cnt <= '0;
            relu_hold <= '0;
        end else begin
            if (state == ST_IDLE && start) begin
                groups_q  <= cfg_groups;
                pixels_q  <= cfg_pixels;
                group_cnt <= '0;
                pixel_cnt <= '0;
            end else if (fire) begin
                if (last_group) begin
                    group_cnt <= '0;
                    pixel_cnt <= pixel_cnt + 16'd1;
                end else begin
                    group_cnt <= group_cnt + 8'd1;
                end
            end
            if (fire) relu_hold <= in_data;
        end
    end

    // Valid/tag shadow of the ReLU array; its tail lines up with relu_out
    always_ff @(posedge clk) begin
        if (rst) begin
            dl_vld <= '0;
            for (int i = 0; i < RELU_LAT; i++) dl_tag[i] <= '0;
        end else begin
            dl_vld[0] <= fire;
            dl_tag[0] <= {last_beat, last_group};
            for (int i = 1; i < RELU_LAT; i++) begin
                dl_vld[i] <= dl_vld[i-1];
                dl_tag[i] <= dl_tag[i-1];
            end
        end
    end

    sync_fifo_tagged #(
        .WIDTH (W),
        .DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (dl_vld[RELU_LAT-1]),
        .push_data (relu_out),
        .push_tags (dl_tag[RELU_LAT-1]),
        .pop       (out_valid && out_ready),
        .pop_data  (out_data),
        .pop_tags  (head_tags),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign out_valid      = !fifo_empty;
    assign out_last_group = head_tags[0];
    assign out_last       = head_tags[1];

endmodule

// File: tb/tb_conv2d_relu_sched.sv
// tb/tb_conv2d_relu_sched.sv - job table plus corner sequences with a scoreboard of rectified beats
module tb_conv2d_relu_sched;

    localparam int DW = 14;
    localparam int LN = 16;
    localparam int RL = 1;
    localparam int FD = 4;
    localparam int W  = DW * LN;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [7:0]    cfg_groups;
    logic [15:0]   cfg_pixels;
    logic          busy;
    logic          done;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          relu_en;
    logic [W-1:0]  relu_data;
    logic [W-1:0]  relu_out;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          out_last_group;
    logic          out_last;

    always #5 clk = ~clk;

    conv2d_relu_sched #(
        .DATA_WIDTH (DW),
        .LANES      (LN),
        .RELU_LAT   (RL),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .cfg_groups     (cfg_groups),
        .cfg_pixels     (cfg_pixels),
        .busy           (busy),
        .done           (done),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .relu_en        (relu_en),
        .relu_data      (relu_data),
        .relu_out       (relu_out),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_last_group (out_last_group),
        .out_last       (out_last)
    );

    function automatic logic [W-1:0] relu_ref(input logic [W-1:0] d);
        logic [W-1:0]  r;
        logic [DW-1:0] lane;
        r = '0;
        for (int l = 0; l < LN; l++) begin
            lane = d[l*DW +: DW];
            r[l*DW +: DW] = lane[DW-1] ? '0 : lane;
        end
        return r;
    endfunction

    // External ReLU array: RL register stages
    logic [W-1:0] relu_pipe [RL];
    always @(posedge clk) begin
        relu_pipe[0] <= relu_ref(relu_data);
        for (int i = 1; i < RL; i++) relu_pipe[i] <= relu_pipe[i-1];
    end
    assign relu_out = relu_pipe[RL-1];

    typedef struct {
        logic [W-1:0] data;
        logic         lg;
        logic         l;
    } exp_t;

    typedef struct {
        int g;
        int p;
        int ip;
        int op;
        int beats;
        int done_at;
    } job_t;

    exp_t sb[$];
    job_t jobs[7];

    int n_chk = 0;
    int n_fail = 0;
    int m_g, m_p, m_G, m_P;
    int fired, popped, cyc, done_cnt, done_cyc, first_fire, first_out;
    logic [W-1:0] last_rd;

    task automatic chk_int(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_vec(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] rand_beat();
        logic [W-1:0] d;
        d = '0;
        for (int l = 0; l < LN; l++) begin
            case ($urandom_range(0, 7))
                0:       d[l*DW +: DW] = 14'h2000;
                1:       d[l*DW +: DW] = 14'h1FFF;
                2:       d[l*DW +: DW] = 14'h0000;
                3:       d[l*DW +: DW] = 14'h3FFF;
                default: d[l*DW +: DW] = DW'($urandom);
            endcase
        end
        return d;
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk_int({tag, ".busy"},           int'(busy), 0);
        chk_int({tag, ".done"},           int'(done), 0);
        chk_int({tag, ".in_ready"},       int'(in_ready), 0);
        chk_int({tag, ".relu_en"},        int'(relu_en), 0);
        chk_vec({tag, ".relu_data"},      relu_data, '0);
        chk_int({tag, ".out_valid"},      int'(out_valid), 0);
        chk_vec({tag, ".out_data"},       out_data, '0);
        chk_int({tag, ".out_last_group"}, int'(out_last_group), 0);
        chk_int({tag, ".out_last"},       int'(out_last), 0);
    endtask

    task automatic step(input bit iv, input bit orr, input bit st, input logic [7:0] g, input logic [15:0] p);
        exp_t e;
        @(posedge clk);
        #1;
        start      = st;
        cfg_groups = g;
        cfg_pixels = p;
        in_valid   = iv;
        in_data    = rand_beat();
        out_ready  = orr;
        #1;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        chk_int("relu_en", int'(relu_en), int'(in_valid && in_ready));
        if (in_valid && in_ready) begin
            e.lg   = (m_g == m_G - 1);
            e.l    = e.lg && (m_p == m_P - 1);
            e.data = relu_ref(in_data);
            sb.push_back(e);
            last_rd = in_data;
            if (first_fire < 0) first_fire = cyc;
            fired++;
            if (e.lg) begin
                m_g = 0;
                m_p++;
            end else begin
                m_g++;
            end
        end
        chk_vec("relu_data", relu_data, last_rd);
        if (out_valid && out_ready) begin
            if (first_out < 0) first_out = cyc;
            popped++;
            if (sb.size() == 0) begin
                chk_int("unexpected_out_beat", popped, fired);
            end else begin
                e = sb.pop_front();
                chk_vec("out_data", out_data, e.data);
                chk_int("out_last_group", int'(out_last_group), int'(e.lg));
                chk_int("out_last", int'(out_last), int'(e.l));
            end
        end
        cyc++;
    endtask

    task automatic begin_job(input int g, input int p, input bit iv, input bit orr);
        m_G = g; m_P = p; m_g = 0; m_p = 0;
        fired = 0; popped = 0; cyc = 0; done_cnt = 0;
        done_cyc = -1; first_fire = -1; first_out = -1;
        step(iv, orr, 1'b1, 8'(g), 16'(p));
    endtask

    task automatic run_to_done(input string tag, input int ip, input int op, input int bound);
        int n;
        n = 0;
        while (done_cnt == 0 && n < bound) begin
            step($urandom_range(1, 100) <= ip, $urandom_range(1, 100) <= op, 1'b0, 8'd0, 16'd0);
            n++;
        end
        if (done_cnt == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s.timeout: no done after %0d cycles", tag, bound);
        end
    endtask

    task automatic end_job(input string tag, input int beats);
        step(1'b0, 1'b1, 1'b0, 8'd0, 16'd0);
        chk_int({tag, ".done_width"}, int'(done), 0);
        chk_int({tag, ".busy_after"}, int'(busy), 0);
        chk_int({tag, ".done_count"}, done_cnt, 1);
        chk_int({tag, ".fired"}, fired, beats);
        chk_int({tag, ".popped"}, popped, beats);
        chk_int({tag, ".sb_left"}, sb.size(), 0);
    endtask

    initial begin
        jobs[0] = '{g: 2,  p: 3, ip: 100, op: 100, beats: 6,  done_at: 10};
        jobs[1] = '{g: 1,  p: 5, ip: 100, op: 100, beats: 5,  done_at: 9};
        jobs[2] = '{g: 0,  p: 5, ip: 100, op: 100, beats: 0,  done_at: 1};
        jobs[3] = '{g: 4,  p: 0, ip: 100, op: 100, beats: 0,  done_at: 1};
        jobs[4] = '{g: 1,  p: 1, ip: 100, op: 100, beats: 1,  done_at: 5};
        jobs[5] = '{g: 3,  p: 4, ip: 60,  op: 70,  beats: 12, done_at: -1};
        jobs[6] = '{g: 16, p: 2, ip: 50,  op: 50,  beats: 32, done_at: -1};

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; cfg_groups = '0; cfg_pixels = '0; last_rd = '0;
        m_G = 1; m_P = 1; m_g = 0; m_p = 0;
        repeat (3) @(posedge clk);
        #2;
        check_reset_outputs("por");
        @(posedge clk);
        #1 rst = 1'b0;

        foreach (jobs[j]) begin
            string tag;
            tag = $sformatf("job%0d", j);
            begin_job(jobs[j].g, jobs[j].p, 1'b1, 1'b1);
            run_to_done(tag, jobs[j].ip, jobs[j].op, 3000);
            if (jobs[j].done_at >= 0) chk_int({tag, ".done_cycle"}, done_cyc, jobs[j].done_at);
            if (jobs[j].ip == 100 && jobs[j].beats > 0)
                chk_int({tag, ".latency"}, first_out - first_fire, RL + 1);
            end_job(tag, jobs[j].beats);
        end

        // Stalled output: credit admits exactly FD beats, then everything drains in order
        begin_job(2, 4, 1'b1, 1'b0);
        repeat (12) step(1'b1, 1'b0, 1'b0, 8'd0, 16'd0);
        chk_int("bp.accepted", fired, FD);
        chk_int("bp.in_ready", int'(in_ready), 0);
        chk_int("bp.out_valid", int'(out_valid), 1);
        run_to_done("bp", 100, 100, 200);
        end_job("bp", 8);

        // start during RUN with a different config is ignored
        begin_job(2, 3, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0, 8'd0, 16'd0);
        step(1'b1, 1'b1, 1'b1, 8'd5, 16'd5);
        run_to_done("restart", 100, 100, 200);
        chk_int("restart.done_cycle", done_cyc, 10);
        end_job("restart", 6);

        // Reset after the third beat of eight
        begin_job(2, 4, 1'b1, 1'b1);
        while (fired < 3 && cyc < 20) step(1'b1, 1'b1, 1'b0, 8'd0, 16'd0);
        @(posedge clk);
        #1;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_reset_outputs("midrst");
        sb.delete();
        last_rd = '0;
        done_cnt = 0;
        repeat (4) step(1'b0, 1'b1, 1'b0, 8'd0, 16'd0);
        chk_int("midrst.no_done", done_cnt, 0);
        begin_job(2, 2, 1'b1, 1'b1);
        run_to_done("fresh", 100, 100, 200);
        chk_int("fresh.done_cycle", done_cyc, 8);
        end_job("fresh", 4);

        // Long random-handshake job
        begin_job(10, 100, 1'b1, 1'b1);
        run_to_done("rand1000", 60, 55, 20000);
        end_job("rand1000", 1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/conv2d_relu_sched.md
CONV2D_RELU_SCHED -- requirements
Module: conv2d_relu_sched

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 14, meaning the signed fixed-point width of one lane.
REQ-002 SHALL have parameter LANES, default 16, meaning the number of channels per beat (one channel group).
REQ-003 SHALL have parameter RELU_LAT, default 1, meaning the ReLU array latency in cycles from relu_en to relu_out.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, meaning the output buffer depth; FIFO_DEPTH >= RELU_LAT+2 is mandatory.
REQ-005 SHALL have a single clock; reset is synchronous and active-high. Ports are listed in REQ-006 to REQ-022.
REQ-006 clk  input  1  sole clock; all state updates on the rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 start  input  1  launches a job; sampled only in IDLE.
REQ-009 cfg_groups  input  8  channel groups per pixel; latched on start.
REQ-010 cfg_pixels  input  16  pixels per job; latched on start.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse at job end.
REQ-013 in_valid  input  1  upstream beat valid.
REQ-014 in_ready  output  1  scheduler accepts the beat.
REQ-015 in_data  input  DATA_WIDTH*LANES  conv accumulator beat.
REQ-016 relu_en  output  1  enable to the ReLU array.
REQ-017 relu_data  output  DATA_WIDTH*LANES  data to the ReLU array.
REQ-018 relu_out  input  DATA_WIDTH*LANES  ReLU array result.
REQ-019 out_valid  output  1  output beat valid.
REQ-020 out_ready  input  1  downstream accepts the beat.
REQ-021 out_data  output  DATA_WIDTH*LANES  rectified beat.
REQ-022 out_last_group / out_last  output  1 each  last group of a pixel / last beat of the job.

Function
REQ-023 SHALL implement FSM IDLE, RUN, DRAIN, DONE.
REQ-024 IDLE: start with both cfg values nonzero SHALL go to RUN; start with either cfg value zero SHALL go directly to DONE.
REQ-025 start SHALL be ignored outside IDLE.
REQ-026 RUN: in_ready = (state==RUN) & (fifo_count + inflight < FIFO_DEPTH); the beat fires when in_valid & in_ready.
REQ-027 A fired beat SHALL drive relu_en=1 and relu_data=in_data in the same cycle. When no beat fires, relu_en=0 and relu_data SHALL hold its last value.
REQ-028 SHALL track in-flight beats with a RELU_LAT-deep valid/tag delay line; on exit, relu_out and the tags SHALL be pushed into the FIFO.
REQ-029 group_cnt SHALL count 0..cfg_groups-1 and then wrap, incrementing pixel_cnt. The tags SHALL be last_group=(group_cnt==cfg_groups-1) and last=(last_group & pixel_cnt==cfg_pixels-1).
REQ-030 The beat carrying last SHALL move RUN to DRAIN; in_ready SHALL be 0 from the next cycle.
REQ-031 DRAIN SHALL go to DONE when inflight==0 and the FIFO is empty.
REQ-032 DONE SHALL assert done for exactly one cycle and then go to IDLE.
REQ-033 out_valid SHALL equal !fifo_empty; out_data and the tags SHALL come from the FIFO head; pop on out_valid & out_ready.
REQ-034 A simultaneous push and pop SHALL be legal at any occupancy, including full, and SHALL leave the count unchanged.
REQ-035 The credit rule SHALL guarantee no push into a full FIFO. A push-when-full is an assertion failure.
REQ-036 Throughput SHALL be 1 beat/cycle while out_ready stays high; latency in_data to out_valid SHALL be RELU_LAT+1 cycles.

Reset
REQ-037 On rst, state=IDLE, all counters=0, FIFO empty, delay line cleared, and latched cfg=0.
REQ-038 On rst, outputs SHALL be busy=0, done=0, in_ready=0, relu_en=0, relu_data=0, out_valid=0, out_data=0, out_last_group=0, out_last=0.
REQ-039 A reset mid-job SHALL discard in-flight and buffered beats with no done pulse.

Structure
REQ-040 The FSM state encoding and the FIFO_DEPTH/LANES defaults SHALL live in shared package cnn_accel_pkg.
REQ-041 The output buffer SHALL be a sub-module named sync_fifo_tagged (data plus 2 tag bits, count output).
REQ-042 The ReLU array is external to this block; the scheduler owns its enable.

Verification
REQ-043 Scenario: cfg_groups=2, cfg_pixels=3, in_valid and out_ready held high -> 6 beats, out_last_group on beats 2/4/6, out_last on beat 6 only, done 1 cycle after DRAIN empties.
REQ-044 Scenario: out_ready=0 throughout the job -> exactly FIFO_DEPTH=4 beats accepted, then in_ready=0. Raising out_ready -> remaining beats flow in order with no loss.
REQ-045 Scenario: start with cfg_groups=0 -> DONE next cycle, done pulse, no beats accepted.
REQ-046 Scenario: start asserted during RUN with different cfg -> ignored; original count completes.
REQ-047 Scenario: rst asserted after beat 3 of 8 -> all outputs at reset values next cycle, no done; a fresh job then runs cleanly.
REQ-048 Scenario: random in_valid/out_ready toggling, 1000 beats -> out_data equals max(in_data lane, 0) per lane, in order, with no FIFO overflow assertion.
